// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C command sequencer and its command FIFO.
package i2c_seq_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] TIMEOUT_CODE = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } seq_state_e;

    // 25-bit FIFO entry, MSB first: {rw, two_bytes, addr, data}
    typedef struct packed {
        logic              rw;
        logic              two_bytes;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_entry_t;

    // Writes answer zero; single-byte reads only return the low byte.
    function automatic logic [DATA_W-1:0] rsp_word(input logic              rw,
                                                   input logic              two_bytes,
                                                   input logic [DATA_W-1:0] rd);
        if (!rw) begin
            return '0;
        end
        return two_bytes ? rd : {8'h00, rd[7:0]};
    endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Single-clock command FIFO with asynchronous reset; DEPTH must be a power of two.
module i2c_cmd_fifo
    import i2c_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  cmd_entry_t din,
    output cmd_entry_t dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    cmd_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Feeds queued commands to the i2c master one at a time and returns one response each.
// Optional WAIT_DONE watchdog enabled by I2C_SEQ_TIMEOUT_EN (adds rsp_timeout output).
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned BUSY_WAIT      = 2
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic              cmd_two_bytes,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_rw,
    output logic              busy,
    output logic              m_start,
    output logic              m_rw,
    output logic              m_two_bytes,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_read_data
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    output logic              rsp_timeout
`endif
);

    localparam int unsigned BW_W = $clog2(BUSY_WAIT + 1);

    seq_state_e        state_q;
    logic [BW_W-1:0]   bw_cnt_q;
    logic [DATA_W-1:0] rd_data_q;

    cmd_entry_t fifo_din;
    cmd_entry_t fifo_head;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timed_out_q;
`endif

    assign fifo_din  = '{rw: cmd_rw, two_bytes: cmd_two_bytes, addr: cmd_addr, data: cmd_data};
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && m_ready;

    i2c_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outputs are registered views of the state: m_start/rsp_valid trail ISSUE/RESP by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bw_cnt_q    <= '0;
            rd_data_q   <= '0;
            m_start     <= 1'b0;
            m_rw        <= 1'b0;
            m_two_bytes <= 1'b0;
            m_addr      <= '0;
            m_data      <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_rw      <= 1'b0;
            busy        <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
            rsp_timeout <= 1'b0;
`endif
        end else begin
            m_start   <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= (state_q != ST_IDLE) || !fifo_empty || fifo_push;
`ifdef I2C_SEQ_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        m_rw        <= fifo_head.rw;
                        m_two_bytes <= fifo_head.two_bytes;
                        m_addr      <= fifo_head.addr;
                        m_data      <= fifo_head.data;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    m_start  <= 1'b1;
                    bw_cnt_q <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
                    to_cnt_q    <= '0;
                    timed_out_q <= 1'b0;
`endif
                    state_q  <= ST_WAIT_BUSY;
                end
                // A master that never drops ready is treated as having finished instantly.
                ST_WAIT_BUSY: begin
                    if (!m_ready) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (bw_cnt_q == BW_W'(BUSY_WAIT)) begin
                        rd_data_q <= m_read_data;
                        state_q   <= ST_RESP;
                    end else begin
                        bw_cnt_q <= bw_cnt_q + BW_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (m_ready) begin
                        rd_data_q <= m_read_data;
                        state_q   <= ST_RESP;
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timed_out_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_rw    <= m_rw;
                    rsp_data  <= rsp_word(m_rw, m_two_bytes, rd_data_q);
`ifdef I2C_SEQ_TIMEOUT_EN
                    rsp_timeout <= timed_out_q;
                    if (timed_out_q) begin
                        rsp_data <= TIMEOUT_CODE;
                    end
`endif
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: directed steps plus random traffic against a queue model.
// Timeout checks run only when I2C_SEQ_TIMEOUT_EN is defined.
module tb_i2c_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic        cmd_two_bytes;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_rw;
    logic        busy;
    logic        m_start;
    logic        m_rw;
    logic        m_two_bytes;
    logic [6:0]  m_addr;
    logic [15:0] m_data;
    logic        m_ready;
    logic [15:0] m_read_data;
`ifdef I2C_SEQ_TIMEOUT_EN
    logic        rsp_timeout;
`endif

    logic mst_ready;
    logic hold_low;
    int   total = 0;
    int   bad = 0;
    int   mmode = 0;     // 0: normal master, 1: never drops ready, 2: stuck busy
    int   busy_len = 0;  // 0 selects a random busy time

    typedef struct packed {
        logic        to;
        logic        rw;
        logic [15:0] data;
    } exp_t;

    typedef struct packed {
        logic        rw;
        logic        tb2;
        logic [6:0]  addr;
        logic [15:0] data;
    } iss_t;

    exp_t        exp_q[$];
    iss_t        iss_q[$];
    logic [15:0] rd_q[$];
    iss_t        last_iss;

    assign m_ready = mst_ready & ~hold_low;

    i2c_cmd_sequencer #(
        .FIFO_DEPTH     (4),
        .BUSY_WAIT      (2)
`ifdef I2C_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (20)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_two_bytes (cmd_two_bytes),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_rw        (rsp_rw),
        .busy          (busy),
        .m_start       (m_start),
        .m_rw          (m_rw),
        .m_two_bytes   (m_two_bytes),
        .m_addr        (m_addr),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .m_read_data   (m_read_data)
`ifdef I2C_SEQ_TIMEOUT_EN
        ,
        .rsp_timeout   (rsp_timeout)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Response word the host must see for a completed command.
    function automatic logic [15:0] model_rsp(input logic rw, input logic tb2, input logic [15:0] rdv);
        if (!rw) return 16'h0000;
        return tb2 ? rdv : (rdv & 16'h00FF);
    endfunction

    task automatic push_cmd(input logic rw, input logic tb2, input logic [6:0] a,
                            input logic [15:0] d, input logic [15:0] rdv, input logic to);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", cmd_ready, 1);
        if (cmd_ready === 1'b1) begin
            exp_q.push_back(exp_t'{to: to, rw: rw, data: to ? 16'hDEAD : model_rsp(rw, tb2, rdv)});
            iss_q.push_back(iss_t'{rw: rw, tb2: tb2, addr: a, data: d});
            rd_q.push_back(rdv);
        end
        cmd_valid     = 1'b1;
        cmd_rw        = rw;
        cmd_two_bytes = tb2;
        cmd_addr      = a;
        cmd_data      = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_cycles_left", 32'(n < budget), 1);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        @(negedge clk);
        while (m_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", m_start, 1);
    endtask

    // Model of the i2c master: drops ready the cycle after start, returns read data on completion.
    initial begin : master_model
        logic [15:0] rdv;
        int          n;
        mst_ready   = 1'b1;
        m_read_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && m_start === 1'b1) begin
                rdv = (rd_q.size() != 0) ? rd_q.pop_front() : 16'h0000;
                if (mmode == 1) begin
                    m_read_data = rdv;
                end else begin
                    @(posedge clk);
                    #1 mst_ready = 1'b0;
                    m_read_data = 16'($urandom);
                    if (mmode == 2) begin
                        while (mmode == 2 && rst !== 1'b1) @(posedge clk);
                    end else begin
                        n = (busy_len > 0) ? busy_len : int'($urandom_range(8, 1));
                        repeat (n) @(posedge clk);
                    end
                    #1 m_read_data = rdv;
                    mst_ready = 1'b1;
                end
            end
        end
    end

    initial begin : issue_monitor
        iss_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && m_start === 1'b1) begin
                chk("issue_expected", 32'(iss_q.size() != 0), 1);
                if (iss_q.size() != 0) begin
                    e = iss_q.pop_front();
                    last_iss = e;
                    chk("m_rw", m_rw, e.rw);
                    chk("m_two_bytes", m_two_bytes, e.tb2);
                    chk("m_addr", m_addr, e.addr);
                    if (!e.rw) chk("m_data", m_data, e.data);
                end
            end
        end
    end

    initial begin : rsp_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && rsp_valid === 1'b1) begin
                chk("rsp_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_rw", rsp_rw, e.rw);
`ifdef I2C_SEQ_TIMEOUT_EN
                    chk("rsp_timeout", rsp_timeout, e.to);
`endif
                    chk("m_addr_hold", m_addr, last_iss.addr);
                    if (!last_iss.rw) chk("m_data_hold", m_data, last_iss.data);
                end
            end
        end
    end

    initial begin : main
        rst           = 1'b1;
        hold_low      = 1'b0;
        cmd_valid     = 1'b0;
        cmd_rw        = 1'b0;
        cmd_two_bytes = 1'b0;
        cmd_addr      = 7'h00;
        cmd_data      = 16'h0000;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_m_start", m_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);

        // single write: start latency, pulse width, field values
        busy_len = 15;
        push_cmd(1'b0, 1'b0, 7'h50, 16'haa55, 16'h0000, 1'b0);
        @(negedge clk);
        chk("busy_after_push", busy, 1);
        chk("lat_cycle0", m_start, 0);
        @(negedge clk);
        chk("lat_cycle1", m_start, 0);
        @(negedge clk);
        chk("lat_cycle2", m_start, 1);
        chk("write_m_addr", m_addr, 7'h50);
        chk("write_m_data", m_data, 16'haa55);
        @(negedge clk);
        chk("start_width", m_start, 0);
        drain(200);

        // two-byte and one-byte reads
        push_cmd(1'b1, 1'b1, 7'h50, 16'h0000, 16'ha0a0, 1'b0);
        drain(200);
        push_cmd(1'b1, 1'b0, 7'h50, 16'h0000, 16'ha0a0, 1'b0);
        drain(200);
        busy_len = 0;

        // FIFO full while the master is held busy
        hold_low = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'($urandom), 1'($urandom), 7'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        end
        @(negedge clk);
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_busy", busy, 1);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h7f;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_no_start", m_start, 0);
        chk("held_cmd_ready", cmd_ready, 0);
        hold_low = 1'b0;
        drain(400);

        // master that never drops ready
        mmode = 1;
        push_cmd(1'b0, 1'b1, 7'h2a, 16'h1357, 16'h0000, 1'b0);
        wait_start(10);
        repeat (3) @(negedge clk);
        chk("instant_rsp_early", rsp_valid, 0);
        @(negedge clk);
        chk("instant_rsp_on_time", rsp_valid, 1);
        drain(50);
        push_cmd(1'b1, 1'b1, 7'h2b, 16'h0000, 16'h5ac3, 1'b0);
        drain(50);
        mmode = 0;

        // reset during WAIT_DONE with a second command queued
        mmode = 2;
        push_cmd(1'b0, 1'b0, 7'h11, 16'h1234, 16'h0000, 1'b0);
        push_cmd(1'b1, 1'b1, 7'h22, 16'h0000, 16'hbeef, 1'b0);
        wait_start(10);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_m_start", m_start, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_m_addr", m_addr, 0);
        exp_q.delete();
        iss_q.delete();
        rd_q.delete();
        mmode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("after_rst_idle", busy, 0);

        // random traffic
        for (int i = 0; i < 24; i++) begin
            push_cmd(1'($urandom), 1'($urandom), 7'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        drain(3000);

`ifdef I2C_SEQ_TIMEOUT_EN
        // stuck master: timeout response 20 cycles after entering WAIT_DONE
        mmode = 2;
        push_cmd(1'b1, 1'b1, 7'h33, 16'h0000, 16'hbeef, 1'b1);
        wait_start(10);
        repeat (22) @(negedge clk);
        chk("timeout_rsp_early", rsp_valid, 0);
        @(negedge clk);
        chk("timeout_rsp_on_time", rsp_valid, 1);
        chk("timeout_flag", rsp_timeout, 1);
        mmode = 0;
        drain(100);
`endif

        repeat (5) @(negedge clk);
        chk("final_busy", busy, 0);
        chk("final_cmd_ready", cmd_ready, 1);
        chk("final_exp_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Sits directly upstream of the I2C master (`i2c`), which it feeds.
- Accepts queued transaction commands from a host/control FSM, buffers them in a small FIFO, and issues them one at a time on the master's start/addr/data/rw/two_bytes inputs.
- Tracks the master's `ready` to detect completion, then returns one response per command: read data for reads, zero for writes.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
- BUSY_WAIT, 2, cycles after m_start within which m_ready must fall before the command is treated as complete.
- TIMEOUT_CYCLES, 1023, cycles allowed in WAIT_DONE; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  host presents a command.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_two_bytes  in  1  1 = 16-bit transfer, 0 = 8-bit (low byte).
- cmd_addr  in  7  7-bit slave address.
- cmd_data  in  16  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse per completed command; no backpressure.
- rsp_data  out  16  captured m_read_data for reads, 16'h0000 for writes; masked to [7:0] when two_bytes=0.
- rsp_rw  out  1  rw of the completed command.
- busy  out  1  high whenever state != IDLE or the FIFO is non-empty.
- m_start  out  1  start pulse to the master.
- m_rw  out  1  to master rw.
- m_two_bytes  out  1  to master two_bytes.
- m_addr  out  7  to master addr.
- m_data  out  16  to master data.
- m_ready  in  1  master idle/ready.
- m_read_data  in  16  master read_data.

Behaviour:
- Reset (async, immediate):
  - FIFO emptied; state = IDLE.
  - m_start = 0, m_rw = 0, m_two_bytes = 0, m_addr = 0, m_data = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_rw = 0, busy = 0.
  - cmd_ready = 1 once rst is released.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop only on the IDLE->ISSUE transition.
  - Push while full is not allowed (cmd_ready = 0), even if a pop happens the same cycle.
  - Push and pop in the same cycle when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
  - IDLE: if FIFO non-empty && m_ready, go to ISSUE. The head entry is registered into m_rw/m_two_bytes/m_addr/m_data and popped.
  - ISSUE (exactly 1 cycle): m_start = 1. Go to WAIT_BUSY.
  - WAIT_BUSY: if m_ready == 0, go to WAIT_DONE. If m_ready is still 1 after BUSY_WAIT cycles, go to RESP (master finished instantly or ignored start).
  - WAIT_DONE: when m_ready == 1, capture m_read_data, go to RESP.
  - RESP (1 cycle): rsp_valid = 1 with rsp_data/rsp_rw valid; go to IDLE.
- m_* outputs hold stable from ISSUE through RESP and keep their last value in IDLE.
- m_start is high only in ISSUE.
- Latency: command accepted on edge E into an idle, empty sequencer with m_ready = 1 gives m_start high in the cycle after edge E+2.
- Back-to-back: the next command's ISSUE is no earlier than 1 cycle after RESP (through IDLE).
- m_ready low in IDLE: the sequencer waits; it never issues while the master is busy.
- rsp_data for a read with two_bytes = 0 is {8'h00, m_read_data[7:0]}.

Optional Feature:
- Macro I2C_SEQ_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES without m_ready, go to RESP with rsp_data = 16'hDEAD.
  - Extra output rsp_timeout (1 bit) is high alongside that rsp_valid pulse, and 0 otherwise.
- When undefined: no counter, no rsp_timeout port; WAIT_DONE waits indefinitely.

Decomposition:
- Package i2c_seq_pkg holds:
  - state encoding constants (IDLE = 0 .. RESP = 4);
  - the command field widths ADDR_W = 7, DATA_W = 16;
  - the 25-bit FIFO entry layout {rw, two_bytes, addr, data};
  - the timeout code 16'hDEAD.
- One sub-module: i2c_cmd_fifo, a synchronous single-clock FIFO with async reset, parameter DEPTH and ports push/pop/din/dout/full/empty.

Test Plan:
- Single write: push {rw=0, two_bytes=0, addr=7'h50, data=16'haa55} with a model master (ready drops 1 cycle after start, rises 15 cycles later) -> m_start pulse 1 cycle, m_addr = 50h, m_data = aa55h held until RESP; rsp_valid once, rsp_data = 0000h, rsp_rw = 0.
- Two-byte read: push {rw=1, two_bytes=1, addr=7'h50}, model returns read_data = a0a0h -> rsp_data = a0a0h. Same with two_bytes = 0 -> rsp_data = 00a0h.
- FIFO full: with m_ready held 0, push 5 commands (FIFO_DEPTH = 4) -> 4 accepted, cmd_ready = 0 on the 5th, busy = 1. Release m_ready -> 4 rsp pulses in push order.
- Instant master: m_ready never falls after start -> RESP after BUSY_WAIT = 2 cycles, rsp_valid pulses, sequencer returns to IDLE.
- Reset mid-transaction: assert rst during WAIT_DONE -> m_start/rsp_valid/busy = 0 immediately, FIFO empty, no rsp after release.
- With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 20, m_ready stuck low -> rsp_valid with rsp_timeout = 1 and rsp_data = dead h, 20 cycles after entering WAIT_DONE.
